// File: rtl/pass_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pass_entry_ctrl
// Brief    : Keypad password assembler driving CAM write/compare ports, with
//            unlock/deny reporting, failure counting and timed lockout.
// Revision : 1.0 - initial release
// ============================================================================
module pass_entry_ctrl #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int DIGIT_W     = 2,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          Clk,
    input  logic                          Rest,
    input  logic                          Key_Valid,
    input  logic [DIGIT_W-1:0]            Key_Digit,
    input  logic                          Key_Clear,
    input  logic                          Enroll,
    input  logic [ADDR_WIDTH-1:0]         Enroll_Addr,
    output logic                          Key_Ready,
    output logic                          Writ_Enable,
    output logic [DATA_WIDTH-1:0]         Data_IN,
    output logic [ADDR_WIDTH-1:0]         WR_Addr,
    output logic [DATA_WIDTH-1:0]         CMP_Din,
    input  logic                          Match,
    input  logic                          Busy,
    input  logic [ADDR_WIDTH-1:0]         Match_Addr,
    output logic                          Unlock,
    output logic [ADDR_WIDTH-1:0]         Unlock_Addr,
    output logic                          Deny,
    output logic                          Enroll_Done,
    output logic                          Locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] Fail_Cnt
);

    localparam int c_NUM_DIGITS = DATA_WIDTH / DIGIT_W;
    localparam int c_CNT_W      = $clog2(c_NUM_DIGITS + 1);
    localparam int c_FAIL_W     = $clog2(MAX_FAIL + 1);
    localparam int c_TMR_W      = $clog2(LOCK_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(c_NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ZERO  = '0;
    localparam logic [c_FAIL_W-1:0] c_MAX_FAIL  = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0]  c_LOCK_LOAD = c_TMR_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        S_COLLECT   = 3'd0,
        S_WRITE     = 3'd1,
        S_CMP_SETUP = 3'd2,
        S_CMP_WAIT  = 3'd3,
        S_LOCKOUT   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_buf;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_mode;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [c_FAIL_W-1:0]     r_fail_cnt;
    logic [c_TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0]   r_data_in;
    logic [DATA_WIDTH-1:0]   r_cmp_din;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_unlock_addr;
    logic                    r_unlock;
    logic                    r_deny;
    logic                    r_enroll_done;
    logic                    r_locked;

    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_mode;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [c_FAIL_W-1:0]     w_fail_inc;
    logic                    w_last;
    logic                    w_write;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_lock_enter;
    logic                    w_lock_exit;

    // First digit lands in the MSBs once the entry is complete.
    generate
        if (c_NUM_DIGITS > 1) begin : g_shift_multi
            assign w_shifted = {r_buf[DATA_WIDTH-DIGIT_W-1:0], Key_Digit};
        end else begin : g_shift_single
            assign w_shifted = Key_Digit;
        end
    endgenerate

    // Mode/address come straight from the inputs when the first digit is also the last.
    assign w_mode     = (r_count == c_CNT_ZERO) ? Enroll      : r_mode;
    assign w_addr     = (r_count == c_CNT_ZERO) ? Enroll_Addr : r_addr;
    assign w_fail_inc = r_fail_cnt + 1'b1;

    assign Key_Ready   = (r_state == S_COLLECT) && !Rest;
    assign Writ_Enable = (r_state == S_WRITE) && !Busy;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        w_write      = 1'b0;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_lock_enter = 1'b0;
        w_lock_exit  = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (Key_Valid && !Key_Clear && (r_count == c_CNT_LAST)) begin
                    w_last       = 1'b1;
                    w_state_next = w_mode ? S_WRITE : S_CMP_SETUP;
                end
            end
            S_WRITE: begin
                if (!Busy) begin
                    w_write      = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
            S_CMP_SETUP: begin
                w_state_next = S_CMP_WAIT;
            end
            S_CMP_WAIT: begin
                if (!Busy) begin
                    if (Match) begin
                        w_hit        = 1'b1;
                        w_state_next = S_COLLECT;
                    end else begin
                        w_miss = 1'b1;
                        if (w_fail_inc == c_MAX_FAIL) begin
                            w_lock_enter = 1'b1;
                            w_state_next = S_LOCKOUT;
                        end else begin
                            w_state_next = S_COLLECT;
                        end
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_timer == c_TMR_ONE) begin
                    w_lock_exit  = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
            default: begin
                w_state_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_buf         <= '0;
            r_count       <= '0;
            r_mode        <= 1'b0;
            r_addr        <= '0;
            r_fail_cnt    <= '0;
            r_timer       <= '0;
            r_data_in     <= '0;
            r_cmp_din     <= '0;
            r_wr_addr     <= '0;
            r_unlock_addr <= '0;
            r_unlock      <= 1'b0;
            r_deny        <= 1'b0;
            r_enroll_done <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_unlock      <= w_hit;
            r_deny        <= w_miss;
            r_enroll_done <= w_write;

            // Clear wins over a simultaneous digit.
            if (r_state == S_COLLECT) begin
                if (Key_Clear) begin
                    r_buf   <= '0;
                    r_count <= '0;
                end else if (Key_Valid) begin
                    r_buf <= w_shifted;
                    if (r_count == c_CNT_ZERO) begin
                        r_mode <= Enroll;
                        r_addr <= Enroll_Addr;
                    end
                    if (w_last) begin
                        r_count   <= '0;
                        r_data_in <= w_shifted;
                        r_cmp_din <= w_shifted;
                        r_wr_addr <= w_addr;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end

            if (w_hit) begin
                r_unlock_addr <= Match_Addr;
                r_fail_cnt    <= '0;
            end else if (w_miss) begin
                r_fail_cnt <= w_fail_inc;
            end

            if (w_lock_enter) begin
                r_locked <= 1'b1;
                r_timer  <= c_LOCK_LOAD;
            end else if (r_state == S_LOCKOUT) begin
                r_timer <= r_timer - 1'b1;
                if (w_lock_exit) begin
                    r_locked   <= 1'b0;
                    r_fail_cnt <= '0;
                end
            end
        end
    end

    assign Data_IN     = r_data_in;
    assign WR_Addr     = r_wr_addr;
    assign CMP_Din     = r_cmp_din;
    assign Unlock      = r_unlock;
    assign Unlock_Addr = r_unlock_addr;
    assign Deny        = r_deny;
    assign Enroll_Done = r_enroll_done;
    assign Locked      = r_locked;
    assign Fail_Cnt    = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pass_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pass_entry_ctrl
// Brief    : Directed bench for pass_entry_ctrl with a queue-based reference
//            model checked every cycle plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pass_entry_ctrl;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int KW = 2;
    localparam int MF = 3;
    localparam int LC = 16;
    localparam int ND = DW / KW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Key_Valid = 1'b0;
    logic [KW-1:0] Key_Digit = '0;
    logic          Key_Clear = 1'b0;
    logic          Enroll = 1'b0;
    logic [AW-1:0] Enroll_Addr = '0;
    logic          Match = 1'b0;
    logic          Busy = 1'b0;
    logic [AW-1:0] Match_Addr = '0;
    logic          Key_Ready, Writ_Enable, Unlock, Deny, Enroll_Done, Locked;
    logic [DW-1:0] Data_IN, CMP_Din;
    logic [AW-1:0] WR_Addr, Unlock_Addr;
    logic [1:0]    Fail_Cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pass_entry_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIGIT_W(KW),
        .MAX_FAIL(MF), .LOCK_CYCLES(LC)
    ) dut (
        .Clk(clk), .Rest(rst),
        .Key_Valid(Key_Valid), .Key_Digit(Key_Digit), .Key_Clear(Key_Clear),
        .Enroll(Enroll), .Enroll_Addr(Enroll_Addr),
        .Key_Ready(Key_Ready), .Writ_Enable(Writ_Enable),
        .Data_IN(Data_IN), .WR_Addr(WR_Addr), .CMP_Din(CMP_Din),
        .Match(Match), .Busy(Busy), .Match_Addr(Match_Addr),
        .Unlock(Unlock), .Unlock_Addr(Unlock_Addr), .Deny(Deny),
        .Enroll_Done(Enroll_Done), .Locked(Locked), .Fail_Cnt(Fail_Cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: digits collected in a queue, pending actions as flags/counters.
    bit          m_valid = 1'b0;
    int          m_digits[$];
    bit          m_ent_enroll;
    int          m_ent_addr;
    bit          m_wr_pend;
    int          m_cmp_stage;
    int          m_lock_left;
    int          m_fails;
    int          m_data, m_cmp, m_wraddr, m_uaddr;
    bit          m_unlock, m_deny, m_edone;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_digits.delete();
            m_ent_enroll = 1'b0; m_ent_addr = 0;
            m_wr_pend = 1'b0; m_cmp_stage = 0; m_lock_left = 0; m_fails = 0;
            m_data = 0; m_cmp = 0; m_wraddr = 0; m_uaddr = 0;
            m_unlock = 1'b0; m_deny = 1'b0; m_edone = 1'b0;
        end else if (m_valid) begin
            m_unlock = 1'b0; m_deny = 1'b0; m_edone = 1'b0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (m_wr_pend) begin
                if (!Busy) begin
                    m_wr_pend = 1'b0;
                    m_edone = 1'b1;
                end
            end else if (m_cmp_stage == 1) begin
                m_cmp_stage = 2;
            end else if (m_cmp_stage == 2) begin
                if (!Busy) begin
                    m_cmp_stage = 0;
                    if (Match) begin
                        m_unlock = 1'b1; m_uaddr = int'(Match_Addr); m_fails = 0;
                    end else begin
                        m_deny = 1'b1; m_fails++;
                        if (m_fails == MF) m_lock_left = LC;
                    end
                end
            end else if (Key_Clear) begin
                m_digits.delete();
            end else if (Key_Valid) begin
                if (m_digits.size() == 0) begin
                    m_ent_enroll = Enroll; m_ent_addr = int'(Enroll_Addr);
                end
                m_digits.push_back(int'(Key_Digit));
                if (m_digits.size() == ND) begin
                    int pw;
                    pw = 0;
                    foreach (m_digits[i]) pw = pw * (1 << KW) + m_digits[i];
                    m_data = pw; m_cmp = pw; m_wraddr = m_ent_addr;
                    m_digits.delete();
                    if (m_ent_enroll) m_wr_pend = 1'b1;
                    else m_cmp_stage = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit idle;
            idle = (m_lock_left == 0) && !m_wr_pend && (m_cmp_stage == 0);
            chk("key_ready",   Key_Ready,   idle && !rst);
            chk("writ_enable", Writ_Enable, m_wr_pend && !Busy);
            chk("data_in",     Data_IN,     m_data);
            chk("wr_addr",     WR_Addr,     m_wraddr);
            chk("cmp_din",     CMP_Din,     m_cmp);
            chk("unlock",      Unlock,      m_unlock);
            chk("unlock_addr", Unlock_Addr, m_uaddr);
            chk("deny",        Deny,        m_deny);
            chk("enroll_done", Enroll_Done, m_edone);
            chk("locked",      Locked,      m_lock_left > 0);
            chk("fail_cnt",    Fail_Cnt,    m_fails);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [KW-1:0] d, input logic en, input logic [AW-1:0] a);
        Key_Valid = 1'b1; Key_Digit = d; Enroll = en; Enroll_Addr = a;
        tick();
        Key_Valid = 1'b0;
    endtask

    initial begin
        int lock_len;
        tick();
        @(negedge clk);
        chk("rst_key_ready", Key_Ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", Key_Ready, 1);
        chk("post_rst_locked", Locked, 0);
        chk("post_rst_data", Data_IN, 0);
        tick();

        // Enroll 10,01 into slot 2.
        key(2'b10, 1'b1, 2'd2);
        key(2'b01, 1'b1, 2'd2);
        @(negedge clk);
        chk("enr_we", Writ_Enable, 1);
        chk("enr_data", Data_IN, 4'b1001);
        chk("enr_addr", WR_Addr, 2);
        @(negedge clk);
        chk("enr_we_off", Writ_Enable, 0);
        chk("enr_done", Enroll_Done, 1);
        chk("enr_ready", Key_Ready, 1);
        tick();

        // Compare 10,01 against a hit at slot 2.
        Match = 1'b1; Match_Addr = 2'd2;
        key(2'b10, 1'b0, 2'd0);
        key(2'b01, 1'b0, 2'd0);
        @(negedge clk); chk("cmp_t1_unlock", Unlock, 0);
        @(negedge clk); chk("cmp_t2_unlock", Unlock, 0);
        @(negedge clk);
        chk("cmp_t3_unlock", Unlock, 1);
        chk("cmp_uaddr", Unlock_Addr, 2);
        chk("cmp_fail0", Fail_Cnt, 0);
        tick();

        // Three misses lead to lockout.
        Match = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            key(2'b00, 1'b0, 2'd0);
            key(2'b00, 1'b0, 2'd0);
            @(negedge clk); @(negedge clk); @(negedge clk);
            chk("miss_deny", Deny, 1);
            chk("miss_cnt", Fail_Cnt, i);
            if (i < 3) tick();
        end
        chk("lock_entry", Locked, 1);
        lock_len = 1;
        for (int k = 0; k < 40; k++) begin
            Key_Valid = 1'b1; Key_Digit = 2'(k); Key_Clear = k[0];
            @(negedge clk);
            if (Locked) lock_len++;
            else break;
        end
        Key_Valid = 1'b0; Key_Clear = 1'b0;
        chk("lock_len", lock_len, 16);
        chk("lock_exit_cnt", Fail_Cnt, 0);
        chk("lock_exit_ready", Key_Ready, 1);
        tick();

        // Busy held across compare wait; Match sampled when Busy drops.
        Busy = 1'b1; Match = 1'b0; Match_Addr = 2'd1;
        key(2'b11, 1'b0, 2'd0);
        key(2'b00, 1'b0, 2'd0);
        repeat (5) begin
            @(negedge clk);
            chk("busy_cmp_quiet", Unlock | Deny, 0);
            tick();
        end
        Busy = 1'b0; Match = 1'b1; Match_Addr = 2'd3;
        @(negedge clk); chk("busy_cmp_pre", Unlock, 0);
        tick();
        @(negedge clk);
        chk("busy_cmp_unlock", Unlock, 1);
        chk("busy_cmp_uaddr", Unlock_Addr, 3);
        tick();

        // Busy held across write.
        Busy = 1'b1;
        key(2'b01, 1'b1, 2'd1);
        key(2'b11, 1'b1, 2'd1);
        repeat (5) begin
            @(negedge clk);
            chk("busy_wr_quiet", Writ_Enable, 0);
            tick();
        end
        Busy = 1'b0;
        @(negedge clk);
        chk("busy_wr_we", Writ_Enable, 1);
        chk("busy_wr_data", Data_IN, 4'b0111);
        chk("busy_wr_addr", WR_Addr, 1);
        tick();
        @(negedge clk); chk("busy_wr_done", Enroll_Done, 1);
        tick();

        // Clear beats a simultaneous digit.
        Match = 1'b0;
        key(2'b11, 1'b0, 2'd0);
        Key_Valid = 1'b1; Key_Digit = 2'b10; Key_Clear = 1'b1;
        tick();
        Key_Valid = 1'b0; Key_Clear = 1'b0;
        key(2'b01, 1'b0, 2'd0);
        key(2'b10, 1'b0, 2'd0);
        @(negedge clk); chk("clr_cmp_din", CMP_Din, 4'b0110);
        @(negedge clk); @(negedge clk);
        chk("clr_deny", Deny, 1);
        chk("clr_cnt", Fail_Cnt, 1);
        tick();

        // Reset during lockout at timer 7.
        for (int i = 0; i < 2; i++) begin
            key(2'b10, 1'b0, 2'd0);
            key(2'b10, 1'b0, 2'd0);
            @(negedge clk); @(negedge clk); @(negedge clk);
            if (i == 0) tick();
        end
        chk("rl_locked", Locked, 1);
        repeat (9) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rl_mid_locked", Locked, 1);
        chk("rl_rst_ready", Key_Ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rl_locked_off", Locked, 0);
        chk("rl_cnt", Fail_Cnt, 0);
        chk("rl_ready", Key_Ready, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pass_entry_ctrl.md
Name: pass_entry_ctrl

Overview:
- Keypad-side controller that sits directly upstream of the CAM and drives its write and compare ports.
- Assembles fixed-length passwords from a digit stream.
- In enroll mode it writes the password into a CAM slot; otherwise it compares it against stored entries.
- Reports unlock/deny, counts consecutive failures and enforces a timed lockout.

Parameters:
- DATA_WIDTH, 4, password width in bits; must equal the CAM data width.
- ADDR_WIDTH, 2, CAM address width.
- DIGIT_W, 2, bits per keypad digit. DATA_WIDTH must be a multiple of DIGIT_W. NUM_DIGITS = DATA_WIDTH/DIGIT_W.
- MAX_FAIL, 3, consecutive failed compares that trigger lockout (≥1).
- LOCK_CYCLES, 16, lockout duration in clock cycles (≥1).

Ports:
- Clk  input  1  system clock.
- Rest  input  1  synchronous, active-high reset.
- Key_Valid  input  1  digit strobe; accepted only when Key_Ready=1.
- Key_Digit  input  DIGIT_W  digit value.
- Key_Clear  input  1  discard partial entry.
- Enroll  input  1  sampled with first digit; 1 = write, 0 = compare.
- Enroll_Addr  input  ADDR_WIDTH  target slot, sampled with first digit.
- Key_Ready  output  1  controller accepting digits.
- Writ_Enable  output  1  CAM write strobe.
- Data_IN  output  DATA_WIDTH  CAM write data.
- WR_Addr  output  ADDR_WIDTH  CAM write address.
- CMP_Din  output  DATA_WIDTH  CAM compare data.
- Match  input  1  CAM match flag.
- Busy  input  1  CAM busy.
- Match_Addr  input  ADDR_WIDTH  CAM matching slot.
- Unlock  output  1  one-cycle pulse, password matched.
- Unlock_Addr  output  ADDR_WIDTH  slot of last match; held until next match.
- Deny  output  1  one-cycle pulse, compare failed.
- Enroll_Done  output  1  one-cycle pulse, write issued.
- Locked  output  1  lockout active.
- Fail_Cnt  output  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- Reset: state=COLLECT; buffer, digit count, Fail_Cnt, lock timer, Unlock_Addr, Data_IN, WR_Addr, CMP_Din = 0. Unlock, Deny, Enroll_Done, Locked, Writ_Enable = 0. Key_Ready = 0 while Rest=1.
- Rest aborts any state, including WRITE, CMP_WAIT and LOCKOUT, at the next edge.
- All outputs are registered except Key_Ready (= state==COLLECT && !Rest) and Writ_Enable (= state==WRITE && !Busy).
- COLLECT, digit handling:
  - On Key_Valid: buffer <= {buffer[DATA_WIDTH-DIGIT_W-1:0], Key_Digit}, i.e. the first digit ends up in the MSBs; count++.
  - First digit of an entry latches the Enroll mode and Enroll_Addr.
- COLLECT, Key_Clear: clears buffer and count; it beats a Key_Valid in the same cycle.
- COLLECT, last digit: on acceptance of digit NUM_DIGITS, load Data_IN/CMP_Din with the final buffer and WR_Addr with the latched address. Next state is WRITE (enroll) or CMP_SETUP (compare). Count clears.
- WRITE:
  - Waits while Busy=1.
  - On the first cycle with Busy=0, Writ_Enable=1 for exactly that cycle; the next state is COLLECT and Enroll_Done pulses the following cycle.
  - Fail_Cnt is unchanged by enroll.
- CMP_SETUP: one cycle with CMP_Din stable, then CMP_WAIT.
- CMP_WAIT:
  - Waits indefinitely while Busy=1.
  - On the first cycle with Busy=0, sample Match and Match_Addr.
  - Match=1: Unlock pulses next cycle; Unlock_Addr <= Match_Addr; Fail_Cnt <= 0; go to COLLECT.
  - Match=0: Deny pulses next cycle; Fail_Cnt++. If the new value equals MAX_FAIL, go to LOCKOUT; else go to COLLECT.
- Compare latency: last digit accepted at edge t, Busy=0 → Unlock/Deny high during cycle t+3.
- LOCKOUT:
  - Locked=1 for exactly LOCK_CYCLES cycles; the timer loads LOCK_CYCLES on entry and decrements each cycle.
  - On exit: Fail_Cnt <= 0, Locked=0, go to COLLECT.
  - Key_Valid and Key_Clear are ignored; Deny pulses in the entry cycle as usual.
- CMP_Din/Data_IN hold their last value outside compare/write; the CAM must ignore them unless strobed.
- Key_Valid is ignored in all non-COLLECT states; no digit is buffered.

Test Plan:
- Enroll=1, Enroll_Addr=2, digits 2'b10 then 2'b01, Busy=0 → exactly one Writ_Enable cycle with Data_IN=4'b1001, WR_Addr=2; Enroll_Done pulse next cycle; Key_Ready returns to 1.
- Compare 10,01; CAM model returns Match=1, Match_Addr=2 with Busy=0 → Unlock high in cycle t+3 for one cycle; Unlock_Addr=2; Fail_Cnt=0.
- Three compares of 4'b0000 with Match=0 → Deny pulses ×3, Fail_Cnt 1,2 then lockout. Locked high 16 cycles. Digits during lockout ignored. Fail_Cnt=0 after.
- Busy held 1 for 5 cycles during CMP_WAIT and WRITE → no Unlock/Deny/Writ_Enable until the cycle Busy drops; result uses Match sampled in that cycle.
- Digit 2'b11, then Key_Clear asserted together with Key_Valid → entry discarded. The next two digits 01,10 produce CMP_Din=4'b0110.
- Rest asserted for 1 cycle mid-lockout (timer=7) → Locked=0, Fail_Cnt=0, Key_Ready=1 the cycle after Rest deasserts.
